// File: rtl/seg_digit_scanner_if.sv
// Bus between the 7-segment digit scanner and its surroundings: display value in,
// multiplexed digit, anode enables, slot index and frame pulse out.
interface seg_digit_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [3:0]              digit_out;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output value_in, load,
    input  digit_out, anode_n, digit_idx, frame_done
  );

  modport slave (
    input  value_in, load,
    output digit_out, anode_n, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_digit_scanner.sv
// Time-multiplexed digit scanner with tear-free frame latching and per-slot guard interval.
// Optional leading-zero blanking when SEG_LEADING_ZERO_BLANK_EN is defined.
module seg_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  seg_digit_scanner_if.slave bus
);
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int DATA_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W:0]   GUARD_LIM = (CNT_W + 1)'(GUARD_CYCLES);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [DATA_W-1:0]     disp_reg, disp_next;
  logic [DATA_W-1:0]     pend_reg, pend_next;
  logic                  pend_valid_reg, pend_valid_next;
  logic [NUM_DIGITS-1:0] anode_n_reg, anode_n_next;
  logic [3:0]            digit_out_reg, digit_out_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  slot_wrap, frame_boundary;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;

  // Counters, display latch and guard/drive sequencing.
  always_comb begin
    cnt_next        = cnt_reg + 1'b1;
    idx_next        = idx_reg;
    disp_next       = disp_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    state_next      = state_reg;

    slot_wrap      = (cnt_reg == CNT_LAST);
    frame_boundary = slot_wrap && (idx_reg == IDX_LAST);

    if (slot_wrap) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end

    // A load landing on the boundary bypasses pend so it is shown in the very next frame.
    if (bus.load) begin
      if (frame_boundary) begin
        disp_next       = bus.value_in;
        pend_valid_next = 1'b0;
      end else begin
        pend_next       = bus.value_in;
        pend_valid_next = 1'b1;
      end
    end else if (frame_boundary && pend_valid_reg) begin
      disp_next       = pend_reg;
      pend_valid_next = 1'b0;
    end

    case (state_reg)
      GUARD:   if ({1'b0, cnt_next} >= GUARD_LIM) state_next = DRIVE;
      DRIVE:   if (slot_wrap && (GUARD_CYCLES > 0)) state_next = GUARD;
      default: state_next = GUARD;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi] = disp_next[4*gi +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_first
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = ~|disp_next[DATA_W-1:4*gi];
      end
`else
      assign blank[gi] = 1'b0;
`endif
    end
  endgenerate

  // Outputs are decoded from next-state values so the registered outputs line up with cnt/idx.
  always_comb begin
    anode_n_next    = '1;
    digit_out_next  = nib[idx_next];
    frame_done_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
    if ((state_next == DRIVE) && !blank[idx_next]) begin
      anode_n_next[idx_next] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= GUARD;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      disp_reg       <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      anode_n_reg    <= '1;
      digit_out_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      disp_reg       <= disp_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      anode_n_reg    <= anode_n_next;
      digit_out_reg  <= digit_out_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.anode_n    = anode_n_reg;
  assign bus.digit_out  = digit_out_reg;
  assign bus.digit_idx  = idx_reg;
  assign bus.frame_done = frame_done_reg;
endmodule
